// File: rtl/mac_result_drain.sv
// mac_result_drain
//   Consumer end of the MAC array handshake. A rising edge on mac_ready captures
//   NODES x FEATS accumulator results. Each result is requantised on capture:
//   arithmetic right shift, optional ReLU, then saturation to OUT_W bits.
//   The stored set is streamed out one node per beat on a valid/ready interface.
//   A set that arrives while the previous one is still draining is dropped and
//   reported through the sticky overflow flag.
// Ports
//   clk, rst      clock and synchronous active-high reset
//   mac_ready     results valid from the MAC array (only rising edges capture)
//   mac_res       packed results, element n*FEATS+f = node n, feature f
//   o_valid/o_ready/o_data/o_node/o_last   output stream, one node per beat
//   busy          a captured set is not yet fully drained
//   overflow      sticky, a result set was dropped; clr_ovf clears it
module mac_result_drain #(
  parameter int NODES   = 4,
  parameter int FEATS   = 4,
  parameter int IN_W    = 13,
  parameter int OUT_W   = 7,
  parameter int SHIFT   = 3,
  parameter int RELU_EN = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mac_ready,
  input  logic [NODES*FEATS*IN_W-1:0] mac_res,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [FEATS*OUT_W-1:0]      o_data,
  output logic [$clog2(NODES)-1:0]    o_node,
  output logic                        o_last,
  output logic                        busy,
  output logic                        overflow,
  input  logic                        clr_ovf
);

  localparam int NW = $clog2(NODES);
  localparam int RW = FEATS * OUT_W;
  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          state_q, state_d;
  logic            mr_q;
  logic [NW-1:0]   node_q, node_d;
  logic            ovf_q, ovf_d;
  logic [RW-1:0]   buf_q [NODES];
  logic [RW-1:0]   buf_d [NODES];
  logic [NODES*RW-1:0] quant_flat;
  logic            cap;
  logic            fire;
  logic            last_fire;

  // Requantise every incoming element combinationally; stored only on capture.
  for (genvar gi = 0; gi < NODES * FEATS; gi++) begin : g_quant
    logic signed [IN_W-1:0] x;
    logic signed [IN_W-1:0] y;
    logic [OUT_W-1:0]       q;
    always_comb begin
      x = mac_res[gi*IN_W +: IN_W];
      y = x >>> SHIFT;
      if ((RELU_EN != 0) && y[IN_W-1]) begin
        y = '0;
      end
      if (y > SAT_MAX) begin
        q = SAT_MAX[OUT_W-1:0];
      end else if (y < SAT_MIN) begin
        q = SAT_MIN[OUT_W-1:0];
      end else begin
        q = y[OUT_W-1:0];
      end
    end
    assign quant_flat[gi*OUT_W +: OUT_W] = q;
  end

  // mr_q resets high so a level already present at reset release is not an edge.
  assign cap       = mac_ready & ~mr_q;
  assign fire      = (state_q == SEND) & o_ready;
  assign last_fire = fire & (node_q == NW'(NODES - 1));

  always_comb begin
    state_d = state_q;
    node_d  = node_q;
    // A drop in the same cycle as clr_ovf keeps the flag set.
    ovf_d   = ovf_q & ~clr_ovf;
    for (int n = 0; n < NODES; n++) begin
      buf_d[n] = buf_q[n];
    end

    unique case (state_q)
      IDLE: begin
        if (cap) begin
          for (int n = 0; n < NODES; n++) begin
            buf_d[n] = quant_flat[n*RW +: RW];
          end
          node_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_fire) begin
          node_d = '0;
          // The buffer frees up on this very cycle, so a coincident set is taken.
          if (cap) begin
            for (int n = 0; n < NODES; n++) begin
              buf_d[n] = quant_flat[n*RW +: RW];
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (fire) begin
            node_d = node_q + 1'b1;
          end
          if (cap) begin
            ovf_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mr_q    <= 1'b1;
      node_q  <= '0;
      ovf_q   <= 1'b0;
      for (int n = 0; n < NODES; n++) begin
        buf_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      mr_q    <= mac_ready;
      node_q  <= node_d;
      ovf_q   <= ovf_d;
      for (int n = 0; n < NODES; n++) begin
        buf_q[n] <= buf_d[n];
      end
    end
  end

  assign o_valid  = (state_q == SEND);
  assign busy     = (state_q == SEND);
  assign o_node   = node_q;
  assign o_last   = (state_q == SEND) & (node_q == NW'(NODES - 1));
  assign o_data   = buf_q[node_q];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_result_drain.sv
module tb_mac_result_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         mac_ready;
  logic [207:0] mac_res;
  logic         o_valid;
  logic         o_ready;
  logic [27:0]  o_data;
  logic [1:0]   o_node;
  logic         o_last;
  logic         busy;
  logic         overflow;
  logic         clr_ovf;

  // Second instance with ReLU disabled
  logic         nr_mac_ready;
  logic [207:0] nr_mac_res;
  logic         nr_o_valid;
  logic [27:0]  nr_o_data;
  logic [1:0]   nr_o_node;
  logic         nr_o_last;
  logic         nr_busy;
  logic         nr_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [27:0] data;
    logic [1:0]  node;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t nr_q[$];
  beat_t e_m;
  beat_t e_n;

  always #5 clk = ~clk;

  mac_result_drain dut (
    .clk(clk), .rst(rst), .mac_ready(mac_ready), .mac_res(mac_res),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_node(o_node),
    .o_last(o_last), .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  mac_result_drain #(.RELU_EN(0)) u_nr (
    .clk(clk), .rst(rst), .mac_ready(nr_mac_ready), .mac_res(nr_mac_res),
    .o_valid(nr_o_valid), .o_ready(1'b1), .o_data(nr_o_data), .o_node(nr_o_node),
    .o_last(nr_o_last), .busy(nr_busy), .overflow(nr_overflow), .clr_ovf(1'b0)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [27:0] pk(int f0, int f1, int f2, int f3);
    return {7'(f3), 7'(f2), 7'(f1), 7'(f0)};
  endfunction

  function automatic void push(logic [27:0] d, int n);
    beat_t b;
    b.data = d;
    b.node = 2'(n);
    b.last = (n == 3);
    exp_q.push_back(b);
  endfunction

  // Scoreboard monitors: a beat transfers at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (o_valid && o_ready && !rst) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got node %0d data %0h, expected none", o_node, o_data);
      end else begin
        e_m = exp_q.pop_front();
        chk("beat_data", 64'(o_data), 64'(e_m.data));
        chk("beat_node", 64'(o_node), 64'(e_m.node));
        chk("beat_last", 64'(o_last), 64'(e_m.last));
      end
    end
  end

  always @(negedge clk) begin
    if (nr_o_valid && !rst) begin
      if (nr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL nr_unexpected_beat: got node %0d, expected none", nr_o_node);
      end else begin
        e_n = nr_q.pop_front();
        chk("nr_beat_data", 64'(nr_o_data), 64'(e_n.data));
        chk("nr_beat_node", 64'(nr_o_node), 64'(e_n.node));
        chk("nr_beat_last", 64'(nr_o_last), 64'(e_n.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_el(int n, int f, int v);
    mac_res[(n*4+f)*13 +: 13] = 13'(v);
  endtask

  task automatic pulse();
    mac_ready = 1'b1;
    tick();
    mac_ready = 1'b0;
  endtask

  task automatic wait_drain(string nm);
    int n = 0;
    while ((exp_q.size() != 0 || nr_q.size() != 0 || o_valid || nr_o_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(n < 200), 64'd1);
    tick();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; mac_ready = 1'b0; mac_res = '0; o_ready = 1'b1; clr_ovf = 1'b0;
    nr_mac_ready = 1'b0; nr_mac_res = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_o_node", 64'(o_node), 64'd0);
    chk("rst_o_last", 64'(o_last), 64'd0);
    chk("rst_o_data", 64'(o_data), 64'd0);
    tick();

    // Basic drain: all 100 -> 12
    for (int n = 0; n < 4; n++) for (int f = 0; f < 4; f++) set_el(n, f, 100);
    for (int n = 0; n < 4; n++) push(pk(12, 12, 12, 12), n);
    pulse();
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_valid) cnt++;
    end
    chk("basic_valid_cycles", 64'(cnt), 64'd4);
    wait_drain("basic_drain");

    // Saturation and ReLU
    for (int n = 0; n < 4; n++) begin
      set_el(n, 0, 2000); set_el(n, 1, -40); set_el(n, 2, 7); set_el(n, 3, -4096);
      push(pk(63, 0, 0, 0), n);
    end
    pulse();
    wait_drain("relu_drain");

    // ReLU disabled instance: -4000 -> -64, -40 -> -5
    for (int n = 0; n < 4; n++) begin
      nr_mac_res[(n*4+0)*13 +: 13] = 13'(-4000);
      nr_mac_res[(n*4+1)*13 +: 13] = 13'(-40);
      nr_mac_res[(n*4+2)*13 +: 13] = 13'(100);
      nr_mac_res[(n*4+3)*13 +: 13] = 13'(0);
      nr_q.push_back('{data: pk(-64, -5, 12, 0), node: 2'(n), last: (n == 3)});
    end
    nr_mac_ready = 1'b1;
    tick();
    nr_mac_ready = 1'b0;
    wait_drain("norelu_drain");

    // Backpressure: o_ready low for 5 cycles from the first beat
    for (int n = 0; n < 4; n++) begin
      for (int f = 0; f < 4; f++) set_el(n, f, 8 * (10 + n + f));
      push(pk(10 + n, 11 + n, 12 + n, 13 + n), n);
    end
    o_ready = 1'b0;
    pulse();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(o_valid), 64'd1);
      chk("bp_node", 64'(o_node), 64'd0);
      chk("bp_data", 64'(o_data), 64'(pk(10, 11, 12, 13)));
    end
    tick();
    o_ready = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_valid) cnt++;
    end
    chk("bp_drain_cycles", 64'(cnt), 64'd4);
    wait_drain("bp_drain");

    // Overflow: second edge while stalled
    for (int n = 0; n < 4; n++) for (int f = 0; f < 4; f++) set_el(n, f, 100);
    for (int n = 0; n < 4; n++) push(pk(12, 12, 12, 12), n);
    o_ready = 1'b0;
    pulse();
    tick();
    for (int n = 0; n < 4; n++) for (int f = 0; f < 4; f++) set_el(n, f, 200);
    pulse();
    @(negedge clk);
    chk("ovf_set", 64'(overflow), 64'd1);
    tick();
    o_ready = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_sticky", 64'(overflow), 64'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clr", 64'(overflow), 64'd0);
    tick();

    // mac_ready held across reset release
    rst = 1'b1;
    mac_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("hold_no_valid", 64'(o_valid), 64'd0);
      chk("hold_no_busy", 64'(busy), 64'd0);
    end
    tick();
    mac_ready = 1'b0;
    tick();

    // Second edge exactly on the final handshake
    for (int n = 0; n < 4; n++) for (int f = 0; f < 4; f++) set_el(n, f, 100);
    for (int n = 0; n < 4; n++) push(pk(12, 12, 12, 12), n);
    for (int n = 0; n < 4; n++) push(pk(25, 25, 25, 25), n);
    pulse();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_valid_a", 64'(o_valid), 64'd1);
      tick();
    end
    for (int n = 0; n < 4; n++) for (int f = 0; f < 4; f++) set_el(n, f, 200);
    mac_ready = 1'b1;
    @(negedge clk);
    chk("b2b_last_a", 64'(o_last), 64'd1);
    tick();
    mac_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_valid_b", 64'(o_valid), 64'd1);
      tick();
    end
    @(negedge clk);
    chk("b2b_end_valid", 64'(o_valid), 64'd0);
    chk("b2b_no_ovf", 64'(overflow), 64'd0);
    wait_drain("b2b_drain");

    // Reset mid-transfer at beat 2
    for (int n = 0; n < 2; n++) push(pk(12, 12, 12, 12), n);
    for (int n = 0; n < 4; n++) for (int f = 0; f < 4; f++) set_el(n, f, 100);
    pulse();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_last", 64'(o_last), 64'd0);
    chk("midrst_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
    chk("end_queue_empty", 64'(exp_q.size() + nr_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
